// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: Avalon-MM controller for up to eight active-low 7-segment digits.
// Define HEX_DISPLAY_BLINK_EN to build the BLINK/BLINK_DIV registers and the blink prescaler.
module hex_digit_lane (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] nibble,
   input  logic       dark,
   output logic [6:0] seg
);
   logic [6:0] pat;

   // active-low gfedcba patterns
   always_comb begin
      pat = 7'h7F;
      case (nibble)
         4'h0: pat = 7'h40;
         4'h1: pat = 7'h79;
         4'h2: pat = 7'h24;
         4'h3: pat = 7'h30;
         4'h4: pat = 7'h19;
         4'h5: pat = 7'h12;
         4'h6: pat = 7'h02;
         4'h7: pat = 7'h78;
         4'h8: pat = 7'h00;
         4'h9: pat = 7'h10;
         4'hA: pat = 7'h08;
         4'hB: pat = 7'h03;
         4'hC: pat = 7'h46;
         4'hD: pat = 7'h21;
         4'hE: pat = 7'h06;
         4'hF: pat = 7'h0E;
         default: pat = 7'h7F;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) seg <= 7'h7F;
      else       seg <= dark ? 7'h7F : pat;
   end
endmodule

module hex_display_ctrl #(
   parameter int          NUM_DIGITS      = 8,
   parameter logic [31:0] BLINK_DIV_RESET = 32'd25000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              avs_address,
   input  logic                    avs_write,
   input  logic [31:0]             avs_writedata,
   input  logic                    avs_read,
   output logic [31:0]             avs_readdata,
   output logic [7*NUM_DIGITS-1:0] hex_out
);
   localparam int DW = 4*NUM_DIGITS;

   logic [NUM_DIGITS-1:0][3:0] data;
   logic [NUM_DIGITS-1:0]      blank, blink, lz_dark, dark;
   logic                       lzs, blink_phase, seen;
   logic [31:0]                blink_div_rd, rd_mux;

   always_ff @(posedge clk) begin
      if (reset) begin
         data         <= '0;
         blank        <= '0;
         lzs          <= 1'b0;
         avs_readdata <= '0;
      end else begin
         if (avs_write) begin
            case (avs_address)
               3'd0:    data  <= avs_writedata[DW-1:0];
               3'd1:    blank <= avs_writedata[NUM_DIGITS-1:0];
               3'd3:    lzs   <= avs_writedata[0];
               default: ;
            endcase
         end
         // register file is sampled before this edge's write lands
         if (avs_read) avs_readdata <= rd_mux;
      end
   end

`ifdef HEX_DISPLAY_BLINK_EN
   logic [31:0] blink_div, blink_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         blink       <= '0;
         blink_div   <= BLINK_DIV_RESET;
         blink_cnt   <= BLINK_DIV_RESET;
         blink_phase <= 1'b0;
      end else begin
         if (avs_write && avs_address == 3'd2) blink <= avs_writedata[NUM_DIGITS-1:0];
         // a BLINK_DIV write restarts the half-period, even on a reload cycle
         if (avs_write && avs_address == 3'd4) begin
            blink_div   <= avs_writedata;
            blink_cnt   <= avs_writedata;
            blink_phase <= 1'b0;
         end else if (blink_div == 32'd0) begin
            blink_cnt   <= 32'd0;
            blink_phase <= 1'b0;
         end else if (blink_cnt == 32'd0) begin
            blink_cnt   <= blink_div;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt   <= blink_cnt - 32'd1;
         end
      end
   end

   assign blink_div_rd = blink_div;
`else
   assign blink        = '0;
   assign blink_phase  = 1'b0;
   assign blink_div_rd = '0;
`endif

   // digit i is a leading zero if it and every digit above it are zero
   always_comb begin
      seen    = 1'b0;
      lz_dark = '0;
      for (int i = NUM_DIGITS-1; i >= 0; i--) begin
         if (data[i] != 4'h0 || i == 0) seen = 1'b1;
         lz_dark[i] = lzs && !seen;
      end
   end

   assign dark = blank | lz_dark | (blink & {NUM_DIGITS{blink_phase}});

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         3'd0:    rd_mux[DW-1:0]         = data;
         3'd1:    rd_mux[NUM_DIGITS-1:0] = blank;
         3'd2:    rd_mux[NUM_DIGITS-1:0] = blink;
         3'd3:    rd_mux[0]              = lzs;
         3'd4:    rd_mux                 = blink_div_rd;
         3'd5:    rd_mux[0]              = blink_phase;
         default: rd_mux                 = '0;
      endcase
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
      hex_digit_lane u_lane (
         .clk    (clk),
         .reset  (reset),
         .nibble (data[i]),
         .dark   (dark[i]),
         .seg    (hex_out[7*i +: 7])
      );
   end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: stimulus queues expected reads and hex_out
// snapshots; a negedge monitor pops and compares them.
module tb_hex_display_ctrl;
   localparam logic [31:0] DIV_RST = 32'd25000000;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  avs_address;
   logic        avs_write, avs_read;
   logic [31:0] avs_writedata, avs_readdata;
   logic [55:0] hex_out;

   int errors = 0;
   int checks = 0;
   logic rd_vld = 1'b0;
   logic [31:0] rd_q[$];
   logic [55:0] hex_q[$];

   hex_display_ctrl #(.NUM_DIGITS(8), .BLINK_DIV_RESET(DIV_RST)) dut (
      .clk           (clk),
      .reset         (reset),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .hex_out       (hex_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_vld <= avs_read;

   always @(negedge clk) begin
      logic [31:0] er;
      logic [55:0] eh;
      if (rd_vld) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected got=%h", avs_readdata);
         end else begin
            er = rd_q.pop_front();
            if (avs_readdata !== er) begin
               errors++;
               $display("FAIL readdata got=%h exp=%h t=%0t", avs_readdata, er, $time);
            end
         end
      end
      if (hex_q.size() != 0) begin
         eh = hex_q.pop_front();
         checks++;
         if (hex_out !== eh) begin
            errors++;
            $display("FAIL hex_out got=%h exp=%h t=%0t", hex_out, eh, $time);
         end
      end
   end

   function automatic logic [55:0] rep(input logic [6:0] p);
      return {8{p}};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      tick();
      avs_write = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e);
      avs_address = a; avs_read = 1'b1;
      rd_q.push_back(e);
      tick();
      avs_read = 1'b0;
   endtask

   task automatic exp_hex(input logic [55:0] e);
      hex_q.push_back(e);
   endtask

   initial begin
      logic [55:0] lit0;
      int p;
      reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
      tick(); tick();
      exp_hex(rep(7'h7F));
      reset = 1'b0;
      tick();
      exp_hex(rep(7'h40));

      for (int a = 0; a < 8; a++) begin
`ifdef HEX_DISPLAY_BLINK_EN
         rd(3'(a), (a == 4) ? DIV_RST : 32'd0);
`else
         rd(3'(a), 32'd0);
`endif
      end

      // decode: registered one edge after the data register
      wr(3'd0, 32'h1234ABCF);
      exp_hex(rep(7'h40));
      tick();
      exp_hex({7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h0E});
      rd(3'd0, 32'h1234ABCF);

      // leading-zero suppression
      wr(3'd3, 32'd1);
      wr(3'd0, 32'h00000A00);
      tick();
      exp_hex({{5{7'h7F}}, 7'h08, 7'h40, 7'h40});
      wr(3'd0, 32'h0);
      tick();
      exp_hex({{7{7'h7F}}, 7'h40});
      rd(3'd3, 32'd1);

      // blink on digit0 showing 5, others plain 0
      wr(3'd3, 32'd0);
      wr(3'd0, 32'h5);
      wr(3'd2, 32'h1);
      lit0 = {{7{7'h40}}, 7'h12};
`ifdef HEX_DISPLAY_BLINK_EN
      wr(3'd4, 32'd3);
      for (int j = 1; j <= 16; j++) begin
         p = ((j - 1) / 4) % 2;
         avs_address = 3'd5; avs_read = 1'b1;
         rd_q.push_back(32'(p));
         tick();
         exp_hex(p != 0 ? {{7{7'h40}}, 7'h7F} : lit0);
      end
      avs_read = 1'b0;
      wr(3'd4, 32'd0);
      for (int j = 0; j < 8; j++) begin
         tick();
         exp_hex(lit0);
      end
      rd(3'd5, 32'd0);
      rd(3'd2, 32'd1);
      // write to BLINK_DIV on the reload cycle wins
      wr(3'd4, 32'd3);
      tick(); tick(); tick();
      wr(3'd4, 32'd5);
      rd(3'd5, 32'd0);
      rd(3'd4, 32'd5);
      wr(3'd4, 32'd1);
`else
      wr(3'd4, 32'd3);
      rd(3'd2, 32'd0);
      rd(3'd4, 32'd0);
      for (int j = 0; j < 10; j++) begin
         tick();
         exp_hex(lit0);
      end
      rd(3'd5, 32'd0);
`endif

      // BLANK overrides LZS and BLINK
      wr(3'd0, 32'h15);
      wr(3'd1, 32'h1);
      wr(3'd3, 32'd1);
      tick();
      for (int j = 0; j < 20; j++) begin
         tick();
         exp_hex({{6{7'h7F}}, 7'h79, 7'h7F});
      end
      rd(3'd1, 32'h1);

      // reset mid-blink
      wr(3'd1, 32'd0);
      wr(3'd3, 32'd0);
`ifdef HEX_DISPLAY_BLINK_EN
      wr(3'd4, 32'd3);
      tick(); tick(); tick(); tick();
      rd(3'd5, 32'd1);
`else
      tick();
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_hex(rep(7'h7F));
      rd(3'd5, 32'd0);
      exp_hex(rep(7'h40));
`ifdef HEX_DISPLAY_BLINK_EN
      rd(3'd4, DIV_RST);
      rd(3'd2, 32'd0);
`endif

      // simultaneous read and write of DATA returns the old value
      avs_address = 3'd0; avs_writedata = 32'hDEADBEEF; avs_write = 1'b1; avs_read = 1'b1;
      rd_q.push_back(32'h0);
      tick();
      avs_write = 1'b0; avs_read = 1'b0;
      rd(3'd0, 32'hDEADBEEF);
      rd(3'd7, 32'd0);

      repeat (4) tick();
      if (rd_q.size() != 0 || hex_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain rd_q=%0d hex_q=%0d left, exp 0", rd_q.size(), hex_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
